axi_buf: RTL and testbench



---
 rtl/axi_buf_pkg.sv | 26 ++
 rtl/axi_if.sv | 85 ++++++++
 rtl/axi_buf_fifo.sv | 73 +++++++
 rtl/axi_buf.sv | 100 ++++++++++
 tb/tb_axi_buf.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_buf_pkg.sv
// Shared constants, channel enum and payload sizing for the AXI elastic buffer.
package axi_buf_pkg;

    localparam int unsigned MAX_DEPTH = 16;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned NUM_CHAN  = 5;

    typedef enum logic [2:0] {AW, W, B, AR, R} chan_e;

    // Sum of all non-handshake signal widths of one channel of axi_if.
    function automatic int unsigned payload_width(
        input chan_e       ch,
        input int unsigned addr_w,
        input int unsigned data_w,
        input int unsigned id_w,
        input int unsigned user_w
    );
        case (ch)
            AW, AR:  payload_width = id_w + addr_w + 8 + 3 + 2 + 1 + 4 + 3 + 4 + user_w;
            W:       payload_width = data_w + data_w / 8 + 1 + user_w;
            B:       payload_width = id_w + 2 + user_w;
            default: payload_width = id_w + data_w + 2 + 1 + user_w;
        endcase
    endfunction

endpackage

// File: rtl/axi_if.sv
// Team AXI4 interface; field order here defines the buffer payload packing.
interface axi_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned USER_W = 1
);
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_lock;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic [3:0]          aw_qos;
    logic [USER_W-1:0]   aw_user;
    logic                aw_valid;
    logic                aw_ready;

    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic [USER_W-1:0]   w_user;
    logic                w_valid;
    logic                w_ready;

    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic [USER_W-1:0]   b_user;
    logic                b_valid;
    logic                b_ready;

    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_lock;
    logic [3:0]          ar_cache;
    logic [2:0]          ar_prot;
    logic [3:0]          ar_qos;
    logic [USER_W-1:0]   ar_user;
    logic                ar_valid;
    logic                ar_ready;

    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic [USER_W-1:0]   r_user;
    logic                r_valid;
    logic                r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_buf_fifo.sv
// Generic valid/ready circular FIFO; DEPTH = 0 collapses to a combinational pass-through.
module axi_buf_fifo
    import axi_buf_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready_c,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid_c,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data_c,
    output logic [CNT_W-1:0] occ,
    output logic [CNT_W-1:0] occ_nxt_c
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk;
        assign unused_clk  = clk;
        assign in_ready_c  = out_ready & ~rst;
        assign out_valid_c = in_valid & ~rst;
        assign out_data_c  = in_data;
        assign occ         = '0;
        assign occ_nxt_c   = '0;
    end else begin : g_fifo
        localparam int unsigned    PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [CNT_W-1:0] count;
        logic             push;
        logic             pop;

        // Ready depends only on local occupancy, never on out_ready.
        always_comb begin
            in_ready_c  = 1'b0;
            out_valid_c = 1'b0;
            if (!rst) begin
                in_ready_c  = count < CNT_W'(DEPTH);
                out_valid_c = count != '0;
            end
            push      = in_valid & in_ready_c;
            pop       = out_valid_c & out_ready;
            occ_nxt_c = rst ? '0 : count + CNT_W'(push) - CNT_W'(pop);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
                count <= occ_nxt_c;
            end
        end

        // Storage is deliberately left unreset.
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= in_data;
        end

        assign out_data_c = mem[rd_ptr];
        assign occ        = count;
    end

endmodule

// File: rtl/axi_buf.sv
// Five-channel AXI elastic buffer: payload pack/unpack around one FIFO per channel.
module axi_buf
    import axi_buf_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned USER_W   = 1,
    parameter int unsigned AW_DEPTH = 2,
    parameter int unsigned W_DEPTH  = 4,
    parameter int unsigned B_DEPTH  = 2,
    parameter int unsigned AR_DEPTH = 2,
    parameter int unsigned R_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_if.Slave                      slv,
    axi_if.Master                     mst,
    output logic [NUM_CHAN*CNT_W-1:0] occ,
    output logic                      idle
);

    localparam int unsigned AW_PW = payload_width(AW, ADDR_W, DATA_W, ID_W, USER_W);
    localparam int unsigned W_PW  = payload_width(W,  ADDR_W, DATA_W, ID_W, USER_W);
    localparam int unsigned B_PW  = payload_width(B,  ADDR_W, DATA_W, ID_W, USER_W);
    localparam int unsigned AR_PW = payload_width(AR, ADDR_W, DATA_W, ID_W, USER_W);
    localparam int unsigned R_PW  = payload_width(R,  ADDR_W, DATA_W, ID_W, USER_W);

    logic [AW_PW-1:0] aw_in, aw_out;
    logic [W_PW-1:0]  w_in,  w_out;
    logic [B_PW-1:0]  b_in,  b_out;
    logic [AR_PW-1:0] ar_in, ar_out;
    logic [R_PW-1:0]  r_in,  r_out;

    logic [CNT_W-1:0] occ_ch  [NUM_CHAN];
    logic [CNT_W-1:0] occ_nxt [NUM_CHAN];

    assign aw_in = {slv.aw_id, slv.aw_addr, slv.aw_len, slv.aw_size, slv.aw_burst, slv.aw_lock,
                    slv.aw_cache, slv.aw_prot, slv.aw_qos, slv.aw_user};
    assign {mst.aw_id, mst.aw_addr, mst.aw_len, mst.aw_size, mst.aw_burst, mst.aw_lock,
            mst.aw_cache, mst.aw_prot, mst.aw_qos, mst.aw_user} = aw_out;

    assign w_in = {slv.w_data, slv.w_strb, slv.w_last, slv.w_user};
    assign {mst.w_data, mst.w_strb, mst.w_last, mst.w_user} = w_out;

    assign b_in = {mst.b_id, mst.b_resp, mst.b_user};
    assign {slv.b_id, slv.b_resp, slv.b_user} = b_out;

    assign ar_in = {slv.ar_id, slv.ar_addr, slv.ar_len, slv.ar_size, slv.ar_burst, slv.ar_lock,
                    slv.ar_cache, slv.ar_prot, slv.ar_qos, slv.ar_user};
    assign {mst.ar_id, mst.ar_addr, mst.ar_len, mst.ar_size, mst.ar_burst, mst.ar_lock,
            mst.ar_cache, mst.ar_prot, mst.ar_qos, mst.ar_user} = ar_out;

    assign r_in = {mst.r_id, mst.r_data, mst.r_resp, mst.r_last, mst.r_user};
    assign {slv.r_id, slv.r_data, slv.r_resp, slv.r_last, slv.r_user} = r_out;

    axi_buf_fifo #(.WIDTH(AW_PW), .DEPTH(AW_DEPTH)) u_aw (
        .clk, .rst,
        .in_valid(slv.aw_valid), .in_ready_c(slv.aw_ready), .in_data(aw_in),
        .out_valid_c(mst.aw_valid), .out_ready(mst.aw_ready), .out_data_c(aw_out),
        .occ(occ_ch[AW]), .occ_nxt_c(occ_nxt[AW])
    );

    axi_buf_fifo #(.WIDTH(W_PW), .DEPTH(W_DEPTH)) u_w (
        .clk, .rst,
        .in_valid(slv.w_valid), .in_ready_c(slv.w_ready), .in_data(w_in),
        .out_valid_c(mst.w_valid), .out_ready(mst.w_ready), .out_data_c(w_out),
        .occ(occ_ch[W]), .occ_nxt_c(occ_nxt[W])
    );

    axi_buf_fifo #(.WIDTH(B_PW), .DEPTH(B_DEPTH)) u_b (
        .clk, .rst,
        .in_valid(mst.b_valid), .in_ready_c(mst.b_ready), .in_data(b_in),
        .out_valid_c(slv.b_valid), .out_ready(slv.b_ready), .out_data_c(b_out),
        .occ(occ_ch[B]), .occ_nxt_c(occ_nxt[B])
    );

    axi_buf_fifo #(.WIDTH(AR_PW), .DEPTH(AR_DEPTH)) u_ar (
        .clk, .rst,
        .in_valid(slv.ar_valid), .in_ready_c(slv.ar_ready), .in_data(ar_in),
        .out_valid_c(mst.ar_valid), .out_ready(mst.ar_ready), .out_data_c(ar_out),
        .occ(occ_ch[AR]), .occ_nxt_c(occ_nxt[AR])
    );

    axi_buf_fifo #(.WIDTH(R_PW), .DEPTH(R_DEPTH)) u_r (
        .clk, .rst,
        .in_valid(mst.r_valid), .in_ready_c(mst.r_ready), .in_data(r_in),
        .out_valid_c(slv.r_valid), .out_ready(slv.r_ready), .out_data_c(r_out),
        .occ(occ_ch[R]), .occ_nxt_c(occ_nxt[R])
    );

    assign occ = {occ_ch[R], occ_ch[AR], occ_ch[B], occ_ch[W], occ_ch[AW]};

    // Idle tracks the post-edge counts, so it changes on the same edge as occ.
    always_ff @(posedge clk) begin
        if (rst) idle <= 1'b1;
        else     idle <= (occ_nxt[AW] | occ_nxt[W] | occ_nxt[B] | occ_nxt[AR] | occ_nxt[R]) == '0;
    end

endmodule

// File: tb/tb_axi_buf.sv
// Scoreboard bench for axi_buf: drivers queue expected beats, negedge monitors pop and compare.
module tb_axi_buf;
    import axi_buf_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned USER_W = 1;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_CHAN*CNT_W-1:0] occ;
    logic                      idle;
    int unsigned               cyc = 0;
    int                        n_pass = 0;
    int                        n_total = 0;

    logic [127:0] aw_q[$], w_q[$], b_q[$], ar_q[$], r_q[$];
    int unsigned  w_cyc[$], b_cyc[$];
    int           r_seen = 0;

    axi_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W)) slv_if ();
    axi_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W)) mst_if ();

    axi_buf #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W),
        .AW_DEPTH(0), .W_DEPTH(4), .B_DEPTH(1), .AR_DEPTH(2), .R_DEPTH(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .slv (slv_if),
        .mst (mst_if),
        .occ (occ),
        .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic spurious(input string name, input logic [127:0] act);
        n_total++;
        $display("FAIL %s: unexpected beat %0h, required none", name, act);
    endtask

    function automatic logic [CNT_W-1:0] occ_of(input chan_e c);
        return occ[CNT_W*int'(c) +: CNT_W];
    endfunction

    function automatic logic ready_of(input chan_e c);
        case (c)
            AW:      ready_of = slv_if.aw_ready;
            W:       ready_of = slv_if.w_ready;
            AR:      ready_of = slv_if.ar_ready;
            B:       ready_of = mst_if.b_ready;
            default: ready_of = mst_if.r_ready;
        endcase
    endfunction

    // Bounded wait for the input-side ready; returns at a negedge.
    task automatic wait_ready(input chan_e c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ready_of(c) === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        n_total++;
        $display("FAIL %s_accept_timeout: ready low for 64 cycles, required high", c.name());
    endtask

    task automatic send_w(input logic [63:0] d, input logic l, output int unsigned acc);
        bit ok;
        slv_if.w_data = d; slv_if.w_strb = '1; slv_if.w_last = l; slv_if.w_valid = 1'b1;
        wait_ready(W, ok);
        acc = cyc;
        if (ok) w_q.push_back(128'({d, 8'hFF, l}));
        @(posedge clk); #1;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr);
        bit ok;
        slv_if.ar_id = id; slv_if.ar_addr = addr; slv_if.ar_valid = 1'b1;
        wait_ready(AR, ok);
        if (ok) ar_q.push_back(128'({id, addr}));
        @(posedge clk); #1;
    endtask

    task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
        bit ok;
        mst_if.b_id = id; mst_if.b_resp = resp; mst_if.b_valid = 1'b1;
        wait_ready(B, ok);
        if (ok) b_q.push_back(128'({id, resp}));
        @(posedge clk); #1;
    endtask

    task automatic send_r(input logic [3:0] id, input logic [63:0] d, input logic l);
        bit ok;
        mst_if.r_id = id; mst_if.r_data = d; mst_if.r_last = l; mst_if.r_valid = 1'b1;
        wait_ready(R, ok);
        if (ok) r_q.push_back(128'({id, d, l}));
        @(posedge clk); #1;
    endtask

    // Output monitors: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        logic [127:0] act;
        if (mst_if.aw_valid === 1'b1 && mst_if.aw_ready === 1'b1) begin
            act = 128'({mst_if.aw_id, mst_if.aw_addr, mst_if.aw_len});
            if (aw_q.size() == 0) spurious("aw_out", act);
            else check("aw_payload", act, aw_q.pop_front());
        end
        if (mst_if.w_valid === 1'b1 && mst_if.w_ready === 1'b1) begin
            act = 128'({mst_if.w_data, mst_if.w_strb, mst_if.w_last});
            w_cyc.push_back(cyc);
            if (w_q.size() == 0) spurious("w_out", act);
            else check("w_payload", act, w_q.pop_front());
        end
        if (slv_if.b_valid === 1'b1 && slv_if.b_ready === 1'b1) begin
            act = 128'({slv_if.b_id, slv_if.b_resp});
            b_cyc.push_back(cyc);
            if (b_q.size() == 0) spurious("b_out", act);
            else check("b_payload", act, b_q.pop_front());
        end
        if (mst_if.ar_valid === 1'b1 && mst_if.ar_ready === 1'b1) begin
            act = 128'({mst_if.ar_id, mst_if.ar_addr});
            if (ar_q.size() == 0) spurious("ar_out", act);
            else check("ar_payload", act, ar_q.pop_front());
        end
        if (slv_if.r_valid === 1'b1 && slv_if.r_ready === 1'b1) begin
            act = 128'({slv_if.r_id, slv_if.r_data, slv_if.r_last});
            r_seen++;
            if (r_q.size() == 0) spurious("r_out", act);
            else check("r_payload", act, r_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time 100000, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned acc;
        int unsigned p0;

        {slv_if.aw_id, slv_if.aw_addr, slv_if.aw_len, slv_if.aw_size, slv_if.aw_burst,
         slv_if.aw_lock, slv_if.aw_cache, slv_if.aw_prot, slv_if.aw_qos, slv_if.aw_user} = '0;
        {slv_if.ar_id, slv_if.ar_addr, slv_if.ar_len, slv_if.ar_size, slv_if.ar_burst,
         slv_if.ar_lock, slv_if.ar_cache, slv_if.ar_prot, slv_if.ar_qos, slv_if.ar_user} = '0;
        {slv_if.w_data, slv_if.w_strb, slv_if.w_last, slv_if.w_user} = '0;
        {mst_if.b_id, mst_if.b_resp, mst_if.b_user} = '0;
        {mst_if.r_id, mst_if.r_data, mst_if.r_resp, mst_if.r_last, mst_if.r_user} = '0;
        slv_if.aw_valid = 1'b1;
        slv_if.w_valid  = 1'b1;
        slv_if.ar_valid = 1'b0;
        mst_if.b_valid  = 1'b1;
        mst_if.r_valid  = 1'b0;
        mst_if.aw_ready = 1'b1;
        mst_if.w_ready  = 1'b1;
        mst_if.ar_ready = 1'b1;
        slv_if.b_ready  = 1'b1;
        slv_if.r_ready  = 1'b1;

        // Reset held three cycles with some valids and all readies asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mst_valids", 128'({mst_if.aw_valid, mst_if.w_valid, mst_if.ar_valid}), 128'(0));
        check("rst_slv_valids", 128'({slv_if.b_valid, slv_if.r_valid}), 128'(0));
        check("rst_slv_readies", 128'({slv_if.aw_ready, slv_if.w_ready, slv_if.ar_ready}), 128'(0));
        check("rst_mst_readies", 128'({mst_if.b_ready, mst_if.r_ready}), 128'(0));
        check("rst_occ", 128'(occ), 128'(0));
        check("rst_idle", 128'(idle), 128'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        slv_if.aw_valid = 1'b0;
        slv_if.w_valid  = 1'b0;
        mst_if.b_valid  = 1'b0;
        @(negedge clk);
        check("post_rst_aw_ready", 128'(slv_if.aw_ready), 128'(1));
        check("post_rst_fifo_readies", 128'({slv_if.w_ready, slv_if.ar_ready, mst_if.b_ready, mst_if.r_ready}), 128'(4'hF));

        // AW depth 0: ready and valid pass straight through, occupancy stays 0.
        @(posedge clk); #1;
        mst_if.aw_ready = 1'b0;
        slv_if.aw_id = 4'h5; slv_if.aw_addr = 32'h1234_5678; slv_if.aw_len = 8'h0F;
        slv_if.aw_valid = 1'b1;
        @(negedge clk);
        check("byp_ready_low", 128'(slv_if.aw_ready), 128'(0));
        check("byp_valid_through", 128'(mst_if.aw_valid), 128'(1));
        check("byp_occ_blocked", 128'(occ_of(AW)), 128'(0));
        @(posedge clk); #1;
        mst_if.aw_ready = 1'b1;
        aw_q.push_back(128'({4'h5, 32'h1234_5678, 8'h0F}));
        @(negedge clk);
        check("byp_ready_high", 128'(slv_if.aw_ready), 128'(1));
        @(posedge clk); #1;
        slv_if.aw_valid = 1'b0;
        check("byp_occ_after", 128'(occ_of(AW)), 128'(0));

        // W streaming burst of 8 with downstream ready held high.
        w_cyc.delete();
        p0 = 0;
        for (int i = 0; i < 8; i++) begin
            send_w(64'hA5A5_0000_0000_0000 | 64'(i), i == 7, acc);
            if (i == 0) p0 = acc;
        end
        slv_if.w_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("w_beat_count", 128'(w_cyc.size()), 128'(8));
        if (w_cyc.size() == 8) begin
            check("w_first_latency", 128'(w_cyc[0] - p0), 128'(1));
            check("w_burst_span", 128'(w_cyc[7] - w_cyc[0]), 128'(7));
        end
        check("w_occ_drained", 128'(occ_of(W)), 128'(0));

        // AR depth 2 with downstream stalled: third request must wait.
        @(posedge clk); #1;
        mst_if.ar_ready = 1'b0;
        send_ar(4'h1, 32'h0000_1000);
        send_ar(4'h2, 32'h0000_2000);
        fork
            send_ar(4'h3, 32'h0000_3000);
            begin
                @(negedge clk);
                check("ar_occ_full", 128'(occ_of(AR)), 128'(2));
                check("ar_ready_full", 128'(slv_if.ar_ready), 128'(0));
                @(negedge clk);
                check("ar_head_held", 128'({mst_if.ar_valid, mst_if.ar_id}), 128'({1'b1, 4'h1}));
                @(posedge clk); #1;
                mst_if.ar_ready = 1'b1;
            end
        join
        slv_if.ar_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("ar_all_out", 128'(ar_q.size()), 128'(0));
        check("ar_occ_drained", 128'(occ_of(AR)), 128'(0));

        // B depth 1: continuous offers yield one response every other cycle.
        @(posedge clk); #1;
        b_cyc.delete();
        for (int i = 0; i < 4; i++) send_b(4'(6 + i), 2'(i));
        mst_if.b_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("b_count", 128'(b_cyc.size()), 128'(4));
        if (b_cyc.size() == 4) begin
            check("b_spacing_first", 128'(b_cyc[1] - b_cyc[0]), 128'(2));
            check("b_spacing_total", 128'(b_cyc[3] - b_cyc[0]), 128'(6));
        end

        // R depth 3 under random upstream ready: order kept across pointer wraps.
        @(posedge clk); #1;
        r_seen = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) send_r(4'(i), 64'hD000 + 64'(i), i == 9);
                mst_if.r_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    @(posedge clk); #1;
                    slv_if.r_ready = 1'($urandom_range(0, 1));
                end
                slv_if.r_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        check("r_beats_seen", 128'(r_seen), 128'(10));
        check("r_all_out", 128'(r_q.size()), 128'(0));

        // Reset while W holds three beats: contents discarded, nothing stale emitted.
        @(posedge clk); #1;
        mst_if.w_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_w(64'hDEAD_0000 + 64'(i), 1'b0, acc);
        slv_if.w_valid = 1'b0;
        @(negedge clk);
        check("w_occ_three", 128'(occ_of(W)), 128'(3));
        @(posedge clk); #1;
        rst = 1'b1;
        w_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_occ_w", 128'(occ_of(W)), 128'(0));
        check("midrst_w_valid", 128'(mst_if.w_valid), 128'(0));
        check("midrst_idle", 128'(idle), 128'(1));
        @(posedge clk); #1;
        mst_if.w_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_w(64'h0000_BEEF, 1'b1, acc);
        slv_if.w_valid = 1'b0;

        repeat (5) @(negedge clk);
        check("end_queues_empty", 128'(aw_q.size() + w_q.size() + b_q.size() + ar_q.size() + r_q.size()), 128'(0));
        check("end_occ", 128'(occ), 128'(0));
        check("end_idle", 128'(idle), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
